// File: rtl/freq_sched_pkg.sv
// Shared constants and types for the frequency-sort input-buffer refill scheduler.
// Sized for a 32-channel, two-entry-per-channel buffer with a 16-deep tag queue.
package freq_sched_pkg;

   localparam int C_LOG      = 5;
   localparam int OUT_LOG    = 4;
   localparam int FIFO_WIDTH = 512;
   localparam int NCH        = 1 << C_LOG;

   // A channel's credit counts its free buffer slots minus its in-flight requests.
   localparam int CREDIT_W = 2;

   typedef logic [C_LOG-1:0]    chnl_idx_t;
   typedef logic [CREDIT_W-1:0] credit_t;

   localparam credit_t CREDIT_MAX = 2'd2;

endpackage

// File: rtl/freq_sched_tag_fifo.sv
// In-order tag queue: holds the channel index of every granted read request so that
// the in-order read responses can be steered to the right channel.
// Push while full is accepted only when a pop happens in the same cycle.
module freq_sched_tag_fifo
   import freq_sched_pkg::*;
(
   input  logic      CLK,
   input  logic      RST,
   input  logic      i_push,
   input  chnl_idx_t i_push_tag,
   input  logic      i_pop,
   output chnl_idx_t o_pop_tag,
   output logic      o_full,
   output logic      o_empty
);

   localparam int                 DEPTH   = 1 << OUT_LOG;
   localparam logic [OUT_LOG:0]   DEPTH_C = (OUT_LOG + 1)'(DEPTH);

   chnl_idx_t          r_mem [DEPTH];
   logic [OUT_LOG-1:0] r_wr_ptr;
   logic [OUT_LOG-1:0] r_rd_ptr;
   logic [OUT_LOG:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign o_full    = (r_count == DEPTH_C);
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_pop_tag = r_mem[r_rd_ptr];

   // Tag storage write port.
   // NOTE: storage is deliberately not reset; the count and pointers alone decide which entries are valid.
   always_ff @(posedge CLK) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_tag;
   end

   // Pointer and occupancy bookkeeping.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/freq_input_buffer_refill_sched.sv
// Refill scheduler for the 32-channel two-entry input buffer of the frequency-sort front end.
// Keeps a per-channel credit, grants eligible channels round-robin, issues one read per free
// slot and steers in-order read responses into the buffer via enq/enq_idx/din.
// Optional build macro FREQ_REFILL_SCHED_STAT_EN adds stat_req_cnt and stat_stall_cnt outputs.
module freq_input_buffer_refill_sched
   import freq_sched_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NCH-1:0]        chnl_en,
   input  logic                  buf_deq,
   input  logic [C_LOG-1:0]      buf_deq_idx,
   output logic                  rd_req,
   output logic [C_LOG-1:0]      rd_req_idx,
   input  logic                  rd_req_rdy,
   input  logic                  rd_rsp_valid,
   input  logic [FIFO_WIDTH-1:0] rd_rsp_data,
   output logic                  enq,
   output logic [C_LOG-1:0]      enq_idx,
   output logic [FIFO_WIDTH-1:0] din,
   output logic                  err
`ifdef FREQ_REFILL_SCHED_STAT_EN
   ,
   output logic [31:0]           stat_req_cnt,
   output logic [31:0]           stat_stall_cnt
`endif
);

   credit_t               r_credit [NCH];
   chnl_idx_t             r_rr_ptr;
   logic                  r_rd_req;
   chnl_idx_t             r_rd_req_idx;
   logic                  r_enq;
   chnl_idx_t             r_enq_idx;
   logic [FIFO_WIDTH-1:0] r_din;
   logic                  r_err;

   logic [NCH-1:0]        w_elig;
   logic [NCH-1:0]        w_inc;
   logic [NCH-1:0]        w_dec;
   logic                  w_any;
   chnl_idx_t             w_pick_idx;
   logic                  w_slot_free;
   logic                  w_grant;
   logic                  w_pop;
   logic                  w_tag_full;
   logic                  w_tag_empty;
   chnl_idx_t             w_pop_tag;
   logic                  w_deq_at_max;

   assign rd_req     = r_rd_req;
   assign rd_req_idx = r_rd_req_idx;
   assign enq        = r_enq;
   assign enq_idx    = r_enq_idx;
   assign din        = r_din;
   assign err        = r_err;

   // The request slot frees up either when idle or when the held request is taken this cycle;
   // a full tag queue only admits a grant when a response pops an entry in the same cycle.
   assign w_slot_free  = ~r_rd_req | rd_req_rdy;
   assign w_pop        = rd_rsp_valid & ~w_tag_empty;
   assign w_grant      = w_any & w_slot_free & (~w_tag_full | w_pop);
   assign w_deq_at_max = buf_deq & (r_credit[buf_deq_idx] == CREDIT_MAX);

   // Per-channel eligibility and credit increment/decrement strobes.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_elig[i] = chnl_en[i] & (r_credit[i] != '0);
         w_inc[i]  = buf_deq & (buf_deq_idx == chnl_idx_t'(i));
         w_dec[i]  = w_grant & (w_pick_idx == chnl_idx_t'(i));
      end
   end

   // Round-robin pick: first eligible channel at or after r_rr_ptr, wrapping.
   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      w_any      = 1'b0;
      w_pick_idx = r_rr_ptr;
      for (int k = 0; k < NCH; k++) begin
         if (!w_any && w_elig[r_rr_ptr + chnl_idx_t'(k)]) begin
            w_any      = 1'b1;
            w_pick_idx = r_rr_ptr + chnl_idx_t'(k);
         end
      end
   end

   // Credit array: grant spends a credit, dequeue returns one, both together cancel out.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < NCH; i++) r_credit[i] <= CREDIT_MAX;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (w_inc[i] && !w_dec[i]) begin
               if (r_credit[i] != CREDIT_MAX) r_credit[i] <= r_credit[i] + 1'b1;
            end else if (w_dec[i] && !w_inc[i]) begin
               r_credit[i] <= r_credit[i] - 1'b1;
            end
         end
      end
   end

   // Request register and round-robin pointer; a request is held until the memory side takes it.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_rd_req     <= 1'b0;
         r_rd_req_idx <= '0;
         r_rr_ptr     <= '0;
      end else if (w_grant) begin
         r_rd_req     <= 1'b1;
         r_rd_req_idx <= w_pick_idx;
         r_rr_ptr     <= w_pick_idx + 1'b1;
      end else if (rd_req_rdy) begin
         r_rd_req     <= 1'b0;
      end
   end

   // Response steering: one registered enqueue per response, tagged with the oldest request.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_enq     <= 1'b0;
         r_enq_idx <= '0;
         r_din     <= '0;
      end else begin
         r_enq <= w_pop;
         if (w_pop) begin
            r_enq_idx <= w_pop_tag;
            r_din     <= rd_rsp_data;
         end
      end
   end

   // Sticky protocol error: dequeue from an empty channel or a response nobody asked for.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_err <= 1'b0;
      end else if (w_deq_at_max || (rd_rsp_valid && w_tag_empty)) begin
         r_err <= 1'b1;
      end
   end

   freq_sched_tag_fifo u_tag_fifo (
      .CLK        (CLK),
      .RST        (RST),
      .i_push     (w_grant),
      .i_push_tag (w_pick_idx),
      .i_pop      (w_pop),
      .o_pop_tag  (w_pop_tag),
      .o_full     (w_tag_full),
      .o_empty    (w_tag_empty)
   );

`ifdef FREQ_REFILL_SCHED_STAT_EN
   logic [31:0] r_stat_req_cnt;
   logic [31:0] r_stat_stall_cnt;

   assign stat_req_cnt   = r_stat_req_cnt;
   assign stat_stall_cnt = r_stat_stall_cnt;

   // Wrapping counters of accepted requests and of cycles the memory side stalled a request.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_stat_req_cnt   <= '0;
         r_stat_stall_cnt <= '0;
      end else begin
         if (r_rd_req && rd_req_rdy)  r_stat_req_cnt   <= r_stat_req_cnt + 1'b1;
         if (r_rd_req && !rd_req_rdy) r_stat_stall_cnt <= r_stat_stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_freq_input_buffer_refill_sched.sv
// Self-checking bench for freq_input_buffer_refill_sched: directed scenarios plus a randomized
// run, scored against a transaction-level model (accepted-request list, response memory,
// per-channel slot usage).
module tb_freq_input_buffer_refill_sched;
   import freq_sched_pkg::*;

   logic                  CLK = 1'b0;
   logic                  RST = 1'b0;
   logic [NCH-1:0]        chnl_en = '0;
   logic                  buf_deq = 1'b0;
   logic [C_LOG-1:0]      buf_deq_idx = '0;
   logic                  rd_req;
   logic [C_LOG-1:0]      rd_req_idx;
   logic                  rd_req_rdy = 1'b0;
   logic                  rd_rsp_valid = 1'b0;
   logic [FIFO_WIDTH-1:0] rd_rsp_data = '0;
   logic                  enq;
   logic [C_LOG-1:0]      enq_idx;
   logic [FIFO_WIDTH-1:0] din;
   logic                  err;
`ifdef FREQ_REFILL_SCHED_STAT_EN
   logic [31:0]           stat_req_cnt;
   logic [31:0]           stat_stall_cnt;
`endif

   freq_input_buffer_refill_sched dut (
      .CLK          (CLK),
      .RST          (RST),
      .chnl_en      (chnl_en),
      .buf_deq      (buf_deq),
      .buf_deq_idx  (buf_deq_idx),
      .rd_req       (rd_req),
      .rd_req_idx   (rd_req_idx),
      .rd_req_rdy   (rd_req_rdy),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_data  (rd_rsp_data),
      .enq          (enq),
      .enq_idx      (enq_idx),
      .din          (din),
      .err          (err)
`ifdef FREQ_REFILL_SCHED_STAT_EN
      ,
      .stat_req_cnt   (stat_req_cnt),
      .stat_stall_cnt (stat_stall_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state.
   logic [C_LOG-1:0] acc_q[$];   // channels of accepted requests, in order
   logic [C_LOG-1:0] pend_q[$];  // accepted requests still awaiting a response
   int               used[NCH];  // in-flight + stored entries per channel
   int               stored[NCH];
   bit               auto_rsp = 1'b0;

   task automatic clear_model();
      acc_q.delete();
      pend_q.delete();
      for (int i = 0; i < NCH; i++) begin
         used[i]   = 0;
         stored[i] = 0;
      end
   endtask

   task automatic do_reset();
      RST          = 1'b0;
      chnl_en      = '0;
      buf_deq      = 1'b0;
      buf_deq_idx  = '0;
      rd_req_rdy   = 1'b0;
      rd_rsp_valid = 1'b0;
      auto_rsp     = 1'b0;
      clear_model();
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST = 1'b1;
   endtask

   // One clock cycle: memory model answers the oldest accepted request, accepted requests are
   // logged and checked for over-commit, and the enqueue one cycle later is scored.
   task automatic tick();
      bit                    have_rsp;
      logic [C_LOG-1:0]      t;
      logic [FIFO_WIDTH-1:0] d;
      have_rsp = 1'b0;
      t = '0;
      d = '0;
      if (auto_rsp && pend_q.size() > 0) begin
         have_rsp = 1'b1;
         t = pend_q.pop_front();
         for (int w = 0; w < FIFO_WIDTH / 32; w++) d[w*32 +: 32] = $urandom;
      end
      rd_rsp_valid = have_rsp;
      rd_rsp_data  = d;
      if (rd_req && rd_req_rdy) begin
         n_tests++;
         if (used[rd_req_idx] >= 2) begin
            n_fail++;
            $display("FAIL overcommit: ch %0d already had %0d in use, required < 2", rd_req_idx, used[rd_req_idx]);
         end
         used[rd_req_idx]++;
         acc_q.push_back(rd_req_idx);
         pend_q.push_back(rd_req_idx);
      end
      if (buf_deq && stored[buf_deq_idx] > 0) begin
         stored[buf_deq_idx]--;
         used[buf_deq_idx]--;
      end
      @(posedge CLK);
      #1;
      n_tests++;
      if (have_rsp) begin
         if (enq !== 1'b1 || enq_idx !== t || din !== d) begin
            n_fail++;
            $display("FAIL enq: got enq=%b idx=%0d din[31:0]=%h, required enq=1 idx=%0d din[31:0]=%h",
                     enq, enq_idx, din[31:0], t, d[31:0]);
         end
         stored[t]++;
      end else if (enq !== 1'b0) begin
         n_fail++;
         $display("FAIL enq_idle: got enq=%b, required 0", enq);
      end
      rd_rsp_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (rd_req !== 1'b0 || rd_req_idx !== '0 || enq !== 1'b0 || enq_idx !== '0 || din !== '0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: got rd_req=%b idx=%0d enq=%b enq_idx=%0d err=%b, required all 0",
                  rd_req, rd_req_idx, enq, enq_idx, err);
      end
      // Build up some state, then reset mid-cycle with no clock edge.
      chnl_en     = '1;
      buf_deq     = 1'b1;
      buf_deq_idx = 5'd5;
      tick();
      buf_deq = 1'b0;
      tick();
      n_tests++;
      if (err !== 1'b1 || rd_req !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_state: got err=%b rd_req=%b, required 1 1", err, rd_req);
      end
      #2;
      RST = 1'b0;
      #1;
      n_tests++;
      if (rd_req !== 1'b0 || rd_req_idx !== '0 || err !== 1'b0 || enq !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got rd_req=%b idx=%0d err=%b enq=%b, required all 0",
                  rd_req, rd_req_idx, err, enq);
      end
`ifdef FREQ_REFILL_SCHED_STAT_EN
      n_tests++;
      if (stat_req_cnt !== 32'd0 || stat_stall_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL stat_reset: got req=%0d stall=%0d, required 0 0", stat_req_cnt, stat_stall_cnt);
      end
`endif
   endtask

   task automatic test_rr_sweep();
      logic [C_LOG-1:0] exp_i;
      do_reset();
      chnl_en    = '1;
      rd_req_rdy = 1'b1;
      auto_rsp   = 1'b1;
      repeat (100) tick();
      n_tests++;
      if (acc_q.size() != 64) begin
         n_fail++;
         $display("FAIL sweep_count: got %0d requests, required 64", acc_q.size());
      end
      for (int k = 0; k < 64 && k < acc_q.size(); k++) begin
         exp_i = k[C_LOG-1:0];
         n_tests++;
         if (acc_q[k] !== exp_i) begin
            n_fail++;
            $display("FAIL sweep_order[%0d]: got idx %0d, required %0d", k, acc_q[k], exp_i);
         end
      end
      n_tests++;
      if (rd_req !== 1'b0 || pend_q.size() != 0) begin
         n_fail++;
         $display("FAIL sweep_idle: got rd_req=%b pending=%0d, required 0 0", rd_req, pend_q.size());
      end
   endtask

   task automatic test_single_chan();
      do_reset();
      chnl_en    = 32'h0000_0004;
      rd_req_rdy = 1'b1;
      auto_rsp   = 1'b1;
      repeat (20) tick();
      n_tests++;
      if (acc_q.size() != 2 || acc_q[0] !== 5'd2 || acc_q[1] !== 5'd2) begin
         n_fail++;
         $display("FAIL single_two: got %0d requests, required 2 on ch 2", acc_q.size());
      end
      buf_deq     = 1'b1;
      buf_deq_idx = 5'd2;
      tick();
      buf_deq = 1'b0;
      repeat (10) tick();
      n_tests++;
      if (acc_q.size() != 3 || acc_q[acc_q.size()-1] !== 5'd2) begin
         n_fail++;
         $display("FAIL single_refill: got %0d requests, required 3 on ch 2", acc_q.size());
      end
   endtask

   task automatic test_stall();
      do_reset();
      chnl_en = '1;
      tick();
      n_tests++;
      if (rd_req !== 1'b1 || rd_req_idx !== 5'd0) begin
         n_fail++;
         $display("FAIL stall_first: got rd_req=%b idx=%0d, required 1 0", rd_req, rd_req_idx);
      end
      for (int c = 0; c < 5; c++) begin
         tick();
         n_tests++;
         if (rd_req !== 1'b1 || rd_req_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got rd_req=%b idx=%0d, required 1 0", c, rd_req, rd_req_idx);
         end
      end
`ifdef FREQ_REFILL_SCHED_STAT_EN
      n_tests++;
      if (stat_stall_cnt !== 32'd5 || stat_req_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL stat_stall: got stall=%0d req=%0d, required 5 0", stat_stall_cnt, stat_req_cnt);
      end
`endif
      rd_req_rdy = 1'b1;
      tick();
      n_tests++;
      if (rd_req !== 1'b1 || rd_req_idx !== 5'd1) begin
         n_fail++;
         $display("FAIL stall_release: got rd_req=%b idx=%0d, required 1 1", rd_req, rd_req_idx);
      end
`ifdef FREQ_REFILL_SCHED_STAT_EN
      n_tests++;
      if (stat_req_cnt !== 32'd1 || stat_stall_cnt !== 32'd5) begin
         n_fail++;
         $display("FAIL stat_req: got req=%0d stall=%0d, required 1 5", stat_req_cnt, stat_stall_cnt);
      end
`endif
   endtask

   task automatic test_tag_full();
      logic [C_LOG-1:0] exp_i;
      do_reset();
      chnl_en    = '1;
      rd_req_rdy = 1'b1;
      repeat (25) tick();
      n_tests++;
      if (acc_q.size() != 16 || rd_req !== 1'b0) begin
         n_fail++;
         $display("FAIL full_block: got %0d requests rd_req=%b, required 16 and 0", acc_q.size(), rd_req);
      end
      for (int k = 0; k < 16 && k < acc_q.size(); k++) begin
         exp_i = k[C_LOG-1:0];
         n_tests++;
         if (acc_q[k] !== exp_i) begin
            n_fail++;
            $display("FAIL full_order[%0d]: got idx %0d, required %0d", k, acc_q[k], exp_i);
         end
      end
      auto_rsp = 1'b1;
      tick();
      auto_rsp = 1'b0;
      n_tests++;
      if (rd_req !== 1'b1 || rd_req_idx !== 5'd16) begin
         n_fail++;
         $display("FAIL full_regrant: got rd_req=%b idx=%0d, required 1 16", rd_req, rd_req_idx);
      end
      repeat (5) tick();
      n_tests++;
      if (acc_q.size() != 17 || rd_req !== 1'b0) begin
         n_fail++;
         $display("FAIL full_one_more: got %0d requests rd_req=%b, required 17 and 0", acc_q.size(), rd_req);
      end
   endtask

   task automatic test_errors();
      do_reset();
      buf_deq     = 1'b1;
      buf_deq_idx = 5'd7;
      tick();
      buf_deq = 1'b0;
      n_tests++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL err_deq_full: got err=%b, required 1", err);
      end
      chnl_en    = 32'h0000_0080;
      rd_req_rdy = 1'b1;
      auto_rsp   = 1'b1;
      repeat (10) tick();
      n_tests++;
      if (acc_q.size() != 2) begin
         n_fail++;
         $display("FAIL err_credit_kept: got %0d requests on ch 7, required 2", acc_q.size());
      end
      do_reset();
      n_tests++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_cleared: got err=%b, required 0", err);
      end
      rd_rsp_valid = 1'b1;
      @(posedge CLK);
      #1;
      rd_rsp_valid = 1'b0;
      n_tests++;
      if (err !== 1'b1 || enq !== 1'b0) begin
         n_fail++;
         $display("FAIL err_rsp_empty: got err=%b enq=%b, required 1 0", err, enq);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      chnl_en    = 32'h0000_0008;
      rd_req_rdy = 1'b1;
      auto_rsp   = 1'b1;
      tick();
      chnl_en = '0;
      tick();
      tick();
      chnl_en     = 32'h0000_0008;
      buf_deq     = 1'b1;
      buf_deq_idx = 5'd3;
      tick();
      buf_deq = 1'b0;
      n_tests++;
      if (rd_req !== 1'b1 || rd_req_idx !== 5'd3) begin
         n_fail++;
         $display("FAIL same_grant: got rd_req=%b idx=%0d, required 1 3", rd_req, rd_req_idx);
      end
      repeat (10) tick();
      n_tests++;
      if (acc_q.size() != 3 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL same_credit: got %0d requests err=%b, required 3 and 0", acc_q.size(), err);
      end
   endtask

   task automatic test_random();
      int c;
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         chnl_en    = $urandom & $urandom;
         rd_req_rdy = ($urandom_range(0, 3) != 0);
         auto_rsp   = ($urandom_range(0, 2) != 0);
         c = $urandom_range(0, NCH - 1);
         buf_deq     = (stored[c] > 0) && ($urandom_range(0, 1) == 1);
         buf_deq_idx = c[C_LOG-1:0];
         tick();
      end
      chnl_en    = '0;
      buf_deq    = 1'b0;
      rd_req_rdy = 1'b1;
      auto_rsp   = 1'b1;
      repeat (40) tick();
      n_tests++;
      if (pend_q.size() != 0 || rd_req !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL random_drain: got pending=%0d rd_req=%b err=%b, required 0 0 0",
                  pend_q.size(), rd_req, err);
      end
      n_tests++;
      if (acc_q.size() < 100) begin
         n_fail++;
         $display("FAIL random_progress: got %0d requests, required at least 100", acc_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_rr_sweep();
      test_single_chan();
      test_stall();
      test_tag_full();
      test_errors();
      test_same_cycle();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/freq_input_buffer_refill_sched.md
# freq_input_buffer_refill_sched

Refill scheduler for the 32-channel two-entry input buffer of the frequency-sort front end. Tracks per-channel free-slot credits, picks channels needing data by round-robin, issues one memory read request per free slot and steers the in-order read responses into the buffer as enq/enq_idx/din. It never over-commits a channel: outstanding requests plus stored entries for a channel never exceed two.

## Interface
- C_LOG, 5: log2 channel count (32 channels)
- FIFO_WIDTH, 512: buffer entry width, (PAYW+KEYW)<<P_LOG
- OUT_LOG, 4: log2 depth of outstanding-request tag queue (16)
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  asynchronous, active-low reset (RST=0 resets)
- chnl_en  in  1<<C_LOG  channel still has data to fetch; 0 masks it from arbitration
- buf_deq  in  1  downstream dequeued one entry from the buffer
- buf_deq_idx  in  C_LOG  channel of that dequeue
- rd_req  out  1  read request valid
- rd_req_idx  out  C_LOG  channel the request refills
- rd_req_rdy  in  1  memory side accepts request
- rd_rsp_valid  in  1  read response valid; responses return in request order, no backpressure
- rd_rsp_data  in  FIFO_WIDTH  response data
- enq  out  1  enqueue into buffer
- enq_idx  out  C_LOG  target channel
- din  out  FIFO_WIDTH  enqueue data
- err  out  1  sticky protocol error

## Operation
- Per-channel credit, 2 bits, range 0..2, reset 2 = free slots minus in-flight requests.
- Eligible channel: chnl_en[i] & credit[i]!=0.
- Grant: when request slot is free (rd_req=0, or rd_req&rd_req_rdy this cycle) and tag queue not full and any channel eligible: pick first eligible at or after rr_ptr (wrapping 31->0), load rd_req_idx, set rd_req, decrement credit, push idx into tag queue, rr_ptr <= granted+1 (mod 32).
- rd_req held with rd_req_idx stable until rd_req_rdy; deasserted after handshake if no new grant.
- buf_deq increments credit of buf_deq_idx. Same-cycle grant and deq on same channel: credit unchanged.
- deq on a channel at credit 2: credit stays 2, err <= 1.
- Response: pop tag queue, register enq=1, enq_idx=tag, din=rd_rsp_data.
- rd_rsp_valid with tag queue empty: no enq, err <= 1.
- chnl_en falling does not cancel issued requests; their responses are still enqueued.
- Reset mid-operation: all state cleared immediately, in-flight responses after reset release count as errors.

## Timing
- Reset values: rd_req 0, rd_req_idx 0, enq 0, enq_idx 0, din 0, err 0, rr_ptr 0, credits 2, tag queue empty.
- Grant to rd_req visible: 1 cycle (registered).
- Throughput: one request per cycle while rd_req_rdy=1 and channels eligible.
- rd_rsp_valid to enq: 1 cycle.
- Credit update from buf_deq visible to arbitration next cycle.
- Tag queue full (16 outstanding): no grants until a response pops; pop and push same cycle allowed when full.

## Configuration
- FREQ_REFILL_SCHED_STAT_EN defined: adds 32-bit outputs stat_req_cnt (accepted requests) and stat_stall_cnt (cycles with rd_req&!rd_req_rdy), both wrap, reset 0.
- Undefined: ports absent, counters not built; all other behaviour identical.

## Structure
- Package freq_sched_pkg: C_LOG, OUT_LOG, FIFO_WIDTH, NCH=1<<C_LOG, credit width/max constant CREDIT_MAX=2.
- Sub-module freq_sched_tag_fifo: synchronous FIFO of C_LOG-bit tags, depth 1<<OUT_LOG, full/empty flags, simultaneous push/pop.
- Round-robin picker and credit array inline in top.

## Test plan
- Reset, chnl_en=all 1, rd_req_rdy=1 -> rd_req indices 0,0,1,1? no: 0,1,...,31 then 0,1,...,31 (64 requests), then rd_req=0 until responses/deqs.
- chnl_en=0x0000_0004, rd_req_rdy=1 -> exactly two requests idx 2; buf_deq idx 2 once -> one more request idx 2.
- rd_req_rdy=0 for 5 cycles -> rd_req and rd_req_idx held constant; stall counter +5 with STAT_EN.
- 16 grants without responses -> 17th blocked; one rd_rsp_valid -> enq next cycle with enq_idx=first tag, then one new grant.
- buf_deq on channel 7 with credit 2 -> err=1, credit 7 stays 2; rd_rsp_valid with empty tag queue -> err=1, enq=0.
- Same-cycle grant and buf_deq on channel 3 at credit 1 -> credit 3 stays 1.
